// File: rtl/vga_ctrl_if.sv
// Pixel request / colour return and VGA pin bundle for vga_ctrl.
//
// Request/data contract: pix_data_req is a valid strobe with no ready.
// While it is high, pix_x/pix_y name the pixel wanted next. The colour
// generator must return that pixel's colour on pix_data exactly one clock
// later (a single register stage). It cannot stall the controller. When
// pix_data_req is low, pix_x/pix_y read 10'h3FF and pix_data is ignored.
interface vga_ctrl_if;
   logic [15:0] pix_data;
   logic [9:0]  pix_x;
   logic [9:0]  pix_y;
   logic        pix_data_req;
   logic        vga_hs;
   logic        vga_vs;
   logic [15:0] vga_rgb;
   logic        frame_start;

   // Timing generator side.
   modport master (
      input  pix_data,
      output pix_x, pix_y, pix_data_req,
      output vga_hs, vga_vs, vga_rgb, frame_start
   );

   // Colour generator and pin side.
   modport slave (
      output pix_data,
      input  pix_x, pix_y, pix_data_req,
      input  vga_hs, vga_vs, vga_rgb, frame_start
   );
endinterface

// File: rtl/vga_ctrl.sv
// VGA timing generator. It defaults to 640x480@60 Hz on a 25 MHz pixel clock.
// The free-running h/v counters produce the pixel requests combinationally,
// one clock ahead of the active region. All pin outputs are registered from
// the same counter state, so the pins share one clock of latency and stay
// aligned with each other.
module vga_ctrl #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_VALID  = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_VALID  = 480,
   parameter int V_FRONT  = 10,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic        Clk_int,
   input  logic        Sys_Rst,
   vga_ctrl_if.master  vga
);

   // Both totals must stay at or below 1023 so that every boundary fits
   // in the 10-bit counters.
   localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam int HA      = H_SYNC + H_BACK;
   localparam int VA      = V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
   localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
   localparam logic [9:0] H_ACT_BEG  = 10'(HA);
   localparam logic [9:0] H_ACT_END  = 10'(HA + H_VALID);
   localparam logic [9:0] V_ACT_BEG  = 10'(VA);
   localparam logic [9:0] V_ACT_END  = 10'(VA + V_VALID);
   // The request window leads the active window by one clock.
   localparam logic [9:0] H_REQ_BEG  = 10'(HA - 1);
   localparam logic [9:0] H_REQ_END  = 10'(HA + H_VALID - 1);

   localparam logic SYNC_ON  = SYNC_POL;
   localparam logic SYNC_OFF = ~SYNC_POL;

   logic [9:0]  h_cnt_q, h_cnt_d;
   logic [9:0]  v_cnt_q, v_cnt_d;
   logic        line_end;

   logic        h_act, v_act, h_req;
   logic        active, req;

   logic        vga_hs_q, vga_hs_d;
   logic        vga_vs_q, vga_vs_d;
   logic [15:0] vga_rgb_q, vga_rgb_d;
   logic        frame_start_q, frame_start_d;

   // Next-state logic for the counters. The line counter moves only on the
   // last clock of a line.
   always_comb begin
      line_end = (h_cnt_q == H_LAST);
      h_cnt_d  = line_end ? 10'd0 : h_cnt_q + 10'd1;
      v_cnt_d  = v_cnt_q;
      if (line_end) begin
         v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end
   end

   // Counter registers. An asynchronous reset drops them back to the top-left corner.
   always_ff @(posedge Clk_int or posedge Sys_Rst) begin
      if (Sys_Rst) begin
         h_cnt_q <= 10'd0;
         v_cnt_q <= 10'd0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Region decode from the current counter state.
   always_comb begin
      h_act  = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
      v_act  = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
      h_req  = (h_cnt_q >= H_REQ_BEG) && (h_cnt_q < H_REQ_END);
      active = h_act && v_act;
      req    = h_req && v_act;
   end

   // The pixel request goes out combinationally. The subtraction happens only inside the window.
   assign vga.pix_data_req = req;
   assign vga.pix_x        = req ? (h_cnt_q - H_REQ_BEG) : 10'h3FF;
   assign vga.pix_y        = req ? (v_cnt_q - V_ACT_BEG) : 10'h3FF;

   // Next values for the pins. The colour is blanked outside the active window.
   always_comb begin
      vga_hs_d      = (h_cnt_q < H_SYNC_END) ? SYNC_ON : SYNC_OFF;
      vga_vs_d      = (v_cnt_q < V_SYNC_END) ? SYNC_ON : SYNC_OFF;
      vga_rgb_d     = active ? vga.pix_data : 16'h0000;
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   end

   // Output registers. Reset holds both syncs inactive and the colour black.
   always_ff @(posedge Clk_int or posedge Sys_Rst) begin
      if (Sys_Rst) begin
         vga_hs_q      <= SYNC_OFF;
         vga_vs_q      <= SYNC_OFF;
         vga_rgb_q     <= 16'h0000;
         frame_start_q <= 1'b0;
      end else begin
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
         vga_rgb_q     <= vga_rgb_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vga.vga_hs      = vga_hs_q;
   assign vga.vga_vs      = vga_vs_q;
   assign vga.vga_rgb     = vga_rgb_q;
   assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Testbench for vga_ctrl.
// dut_a uses the default 640x480 timing with active-low sync.
// dut_b uses a tiny 17x10 raster with active-high sync, so a whole frame fits in a short run.
// After a reset release, n counts the clock edges. When the bench samples after edge n, the counters
// sit at linear position n and the registered pins show position n-1.
module tb_vga_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vga_ctrl_if if_a ();
   vga_ctrl_if if_b ();

   vga_ctrl dut_a (.Clk_int(clk), .Sys_Rst(rst), .vga(if_a));

   vga_ctrl #(
      .H_SYNC(4), .H_BACK(3), .H_VALID(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(2), .V_VALID(5), .V_FRONT(1),
      .SYNC_POL(1'b1)
   ) dut_b (.Clk_int(clk), .Sys_Rst(rst), .vga(if_b));

   // Small raster: HA = 7, VA = 4, the request window is h in [6,14), v in [4,9).
   localparam int BHT = 17;
   localparam int BVT = 10;
   localparam int BFT = 170;

   int          checks   = 0;
   int          failures = 0;
   int          n        = 0;
   bit          ffff_mode = 1'b0;
   logic [15:0] gen_a = 16'h0;
   logic [15:0] gen_b = 16'h0;

   // Expected small-raster colour at output position q.
   function automatic logic [15:0] exp_rgb_b(int q, bit ff);
      int h = q % BHT;
      int v = (q / BHT) % BVT;
      if (h >= 7 && h < 15 && v >= 4 && v < 9)
         return ff ? 16'hFFFF : {6'(v - 4), 10'(h - 7)};
      return 16'h0000;
   endfunction

   function automatic logic exp_req_b(int p);
      int h = p % BHT;
      int v = (p / BHT) % BVT;
      return (h >= 6 && h < 14 && v >= 4 && v < 9);
   endfunction

   function automatic logic [9:0] exp_x_b(int p);
      return exp_req_b(p) ? 10'((p % BHT) - 6) : 10'h3FF;
   endfunction

   function automatic logic [9:0] exp_y_b(int p);
      return exp_req_b(p) ? 10'(((p / BHT) % BVT) - 4) : 10'h3FF;
   endfunction

   // Advance one clock. The registered colour generator drives pix_data from the previous request.
   task automatic step();
      @(negedge clk);
      n++;
      if_a.pix_data = ffff_mode ? 16'hFFFF : gen_a;
      if_b.pix_data = ffff_mode ? 16'hFFFF : gen_b;
      gen_a = {if_a.pix_y[5:0], if_a.pix_x};
      gen_b = {if_b.pix_y[5:0], if_b.pix_x};
   endtask

   task automatic apply_reset(int cyc);
      @(negedge clk);
      rst = 1'b1;
      repeat (cyc) @(negedge clk);
      rst = 1'b0;
      n = 0;
      gen_a = 16'h0;
      gen_b = 16'h0;
   endtask

   task automatic test_reset();
      if_a.pix_data = 16'hFFFF;
      if_b.pix_data = 16'hFFFF;
      rst = 1'b1;
      repeat (10) @(negedge clk);
      checks++; if (if_a.vga_hs !== 1'b1) begin failures++; $display("FAIL rst_a_hs got=%b exp=1", if_a.vga_hs); end
      checks++; if (if_a.vga_vs !== 1'b1) begin failures++; $display("FAIL rst_a_vs got=%b exp=1", if_a.vga_vs); end
      checks++; if (if_a.vga_rgb !== 16'h0) begin failures++; $display("FAIL rst_a_rgb got=%h exp=0000", if_a.vga_rgb); end
      checks++; if (if_a.pix_data_req !== 1'b0) begin failures++; $display("FAIL rst_a_req got=%b exp=0", if_a.pix_data_req); end
      checks++; if (if_a.pix_x !== 10'h3FF) begin failures++; $display("FAIL rst_a_x got=%h exp=3ff", if_a.pix_x); end
      checks++; if (if_a.pix_y !== 10'h3FF) begin failures++; $display("FAIL rst_a_y got=%h exp=3ff", if_a.pix_y); end
      checks++; if (if_a.frame_start !== 1'b0) begin failures++; $display("FAIL rst_a_fs got=%b exp=0", if_a.frame_start); end
      checks++; if (if_b.vga_hs !== 1'b0) begin failures++; $display("FAIL rst_b_hs got=%b exp=0", if_b.vga_hs); end
      checks++; if (if_b.vga_vs !== 1'b0) begin failures++; $display("FAIL rst_b_vs got=%b exp=0", if_b.vga_vs); end
      rst = 1'b0;
      n = 0;
      step();
      checks++; if (if_a.frame_start !== 1'b1) begin failures++; $display("FAIL rel_a_fs1 got=%b exp=1", if_a.frame_start); end
      checks++; if (if_a.vga_hs !== 1'b0) begin failures++; $display("FAIL rel_a_hs1 got=%b exp=0", if_a.vga_hs); end
      checks++; if (if_b.frame_start !== 1'b1) begin failures++; $display("FAIL rel_b_fs1 got=%b exp=1", if_b.frame_start); end
      checks++; if (if_b.vga_hs !== 1'b1) begin failures++; $display("FAIL rel_b_hs1 got=%b exp=1", if_b.vga_hs); end
      step();
      checks++; if (if_a.frame_start !== 1'b0) begin failures++; $display("FAIL rel_a_fs2 got=%b exp=0", if_a.frame_start); end
      if_a.pix_data = 16'h0;
      if_b.pix_data = 16'h0;
   endtask

   task automatic test_sync_timing();
      logic prev_hs = 1'b1;
      logic prev_vs = 1'b1;
      int hs_fall[$];
      int hs_rise = -1;
      int vs_fall = -1;
      int vs_rise = -1;
      int fs_cnt = 0;
      int blank_err = 0;
      int per, wid;
      ffff_mode = 1'b1;
      apply_reset(2);
      while (n < 1700) begin
         step();
         if (prev_hs && !if_a.vga_hs) hs_fall.push_back(n);
         if (!prev_hs && if_a.vga_hs && hs_rise < 0) hs_rise = n;
         if (prev_vs && !if_a.vga_vs && vs_fall < 0) vs_fall = n;
         if (!prev_vs && if_a.vga_vs && vs_rise < 0) vs_rise = n;
         if (if_a.frame_start) fs_cnt++;
         if (if_a.vga_rgb !== 16'h0 || if_a.pix_data_req !== 1'b0) blank_err++;
         prev_hs = if_a.vga_hs;
         prev_vs = if_a.vga_vs;
      end
      ffff_mode = 1'b0;
      per = (hs_fall.size() >= 2) ? hs_fall[1] - hs_fall[0] : -1;
      wid = (hs_fall.size() >= 1) ? hs_rise - hs_fall[0] : -1;
      checks++; if (hs_fall.size() !== 3) begin failures++; $display("FAIL hs_fall_count got=%0d exp=3", hs_fall.size()); end
      checks++; if (wid !== 96) begin failures++; $display("FAIL hs_width got=%0d exp=96", wid); end
      checks++; if (per !== 800) begin failures++; $display("FAIL hs_period got=%0d exp=800", per); end
      checks++; if (vs_fall !== 1) begin failures++; $display("FAIL vs_fall_pos got=%0d exp=1", vs_fall); end
      checks++; if (vs_rise - vs_fall !== 1600) begin failures++; $display("FAIL vs_width got=%0d exp=1600", vs_rise - vs_fall); end
      checks++; if (fs_cnt !== 1) begin failures++; $display("FAIL a_fs_count got=%0d exp=1", fs_cnt); end
      checks++; if (blank_err !== 0) begin failures++; $display("FAIL a_top_blank got=%0d bad samples exp=0", blank_err); end
   endtask

   task automatic test_request_window();
      int req_cnt = 0;
      apply_reset(2);
      while (n < 28142) step();
      checks++; if (if_a.pix_data_req !== 1'b0 || if_a.pix_x !== 10'h3FF) begin failures++; $display("FAIL req_h142 got req=%b x=%h exp req=0 x=3ff", if_a.pix_data_req, if_a.pix_x); end
      while (n < 28800) begin
         step();
         if (if_a.pix_data_req) req_cnt++;
         if (n == 28143) begin
            checks++; if (if_a.pix_data_req !== 1'b1 || if_a.pix_x !== 10'd0 || if_a.pix_y !== 10'd0) begin failures++; $display("FAIL req_first got req=%b x=%0d y=%0d exp 1 0 0", if_a.pix_data_req, if_a.pix_x, if_a.pix_y); end
         end
         if (n == 28144) begin
            checks++; if (if_a.vga_rgb !== 16'h0000) begin failures++; $display("FAIL rgb_pre_active got=%h exp=0000", if_a.vga_rgb); end
         end
         if (n == 28146) begin
            checks++; if (if_a.vga_rgb !== 16'h0001) begin failures++; $display("FAIL rgb_x1 got=%h exp=0001", if_a.vga_rgb); end
         end
         if (n == 28782) begin
            checks++; if (if_a.pix_data_req !== 1'b1 || if_a.pix_x !== 10'd639 || if_a.pix_y !== 10'd0) begin failures++; $display("FAIL req_last got req=%b x=%0d y=%0d exp 1 639 0", if_a.pix_data_req, if_a.pix_x, if_a.pix_y); end
         end
         if (n == 28783) begin
            checks++; if (if_a.pix_data_req !== 1'b0 || if_a.pix_x !== 10'h3FF || if_a.pix_y !== 10'h3FF) begin failures++; $display("FAIL req_end got req=%b x=%h y=%h exp 0 3ff 3ff", if_a.pix_data_req, if_a.pix_x, if_a.pix_y); end
         end
         if (n == 28784) begin
            checks++; if (if_a.vga_rgb !== 16'h027F) begin failures++; $display("FAIL rgb_x639 got=%h exp=027f", if_a.vga_rgb); end
         end
         if (n == 28785) begin
            checks++; if (if_a.vga_rgb !== 16'h0000) begin failures++; $display("FAIL rgb_front_porch got=%h exp=0000", if_a.vga_rgb); end
         end
      end
      checks++; if (req_cnt !== 640) begin failures++; $display("FAIL req_per_line got=%0d exp=640", req_cnt); end
      while (n < 28943) step();
      checks++; if (if_a.pix_data_req !== 1'b1 || if_a.pix_x !== 10'd0 || if_a.pix_y !== 10'd1) begin failures++; $display("FAIL req_line36 got req=%b x=%0d y=%0d exp 1 0 1", if_a.pix_data_req, if_a.pix_x, if_a.pix_y); end
   endtask

   task automatic test_frame_alignment();
      int sync_err = 0, rgb_err = 0, req_err = 0, fs_err = 0;
      int req_cnt = 0, first_bad = -1;
      int q;
      ffff_mode = 1'b0;
      apply_reset(2);
      while (n < 2 * BFT) begin
         step();
         q = n - 1;
         if (if_b.vga_hs !== ((q % BHT) < 4) || if_b.vga_vs !== (((q / BHT) % BVT) < 2)) sync_err++;
         if (if_b.vga_rgb !== exp_rgb_b(q, 1'b0)) begin rgb_err++; if (first_bad < 0) first_bad = n; end
         if (if_b.pix_data_req !== exp_req_b(n) || if_b.pix_x !== exp_x_b(n) || if_b.pix_y !== exp_y_b(n)) req_err++;
         if (if_b.frame_start !== ((q % BFT) == 0)) fs_err++;
         if (if_b.pix_data_req) req_cnt++;
         if (n == 142) begin
            checks++; if (if_b.pix_y !== 10'd4 || if_b.pix_x !== 10'd0) begin failures++; $display("FAIL b_last_row got x=%0d y=%0d exp 0 4", if_b.pix_x, if_b.pix_y); end
         end
         if (n == 159) begin
            checks++; if (if_b.pix_data_req !== 1'b0 || if_b.pix_y !== 10'h3FF) begin failures++; $display("FAIL b_after_rows got req=%b y=%h exp 0 3ff", if_b.pix_data_req, if_b.pix_y); end
         end
      end
      checks++; if (sync_err !== 0) begin failures++; $display("FAIL b_sync got=%0d bad samples exp=0", sync_err); end
      checks++; if (rgb_err !== 0) begin failures++; $display("FAIL b_rgb_align got=%0d bad samples (first n=%0d) exp=0", rgb_err, first_bad); end
      checks++; if (req_err !== 0) begin failures++; $display("FAIL b_req got=%0d bad samples exp=0", req_err); end
      checks++; if (fs_err !== 0) begin failures++; $display("FAIL b_frame_start got=%0d bad samples exp=0", fs_err); end
      checks++; if (req_cnt !== 80) begin failures++; $display("FAIL b_req_total got=%0d exp=80", req_cnt); end
   endtask

   task automatic test_blanking();
      int b_err = 0, a_err = 0, ones = 0;
      ffff_mode = 1'b1;
      apply_reset(2);
      while (n < BFT + 1) begin
         step();
         if (if_b.vga_rgb !== exp_rgb_b(n - 1, 1'b1)) b_err++;
         if (if_b.vga_rgb === 16'hFFFF) ones++;
         if (if_a.vga_rgb !== 16'h0000) a_err++;
      end
      ffff_mode = 1'b0;
      checks++; if (b_err !== 0) begin failures++; $display("FAIL b_blank got=%0d bad samples exp=0", b_err); end
      checks++; if (ones !== 40) begin failures++; $display("FAIL b_active_count got=%0d exp=40", ones); end
      checks++; if (a_err !== 0) begin failures++; $display("FAIL a_blank got=%0d bad samples exp=0", a_err); end
   endtask

   task automatic test_midframe_reset();
      int fs_pos[$];
      int fs1, fs2;
      ffff_mode = 1'b1;
      apply_reset(2);
      while (n < 95) step();
      checks++; if (if_b.vga_rgb !== 16'hFFFF || if_b.pix_data_req !== 1'b1 || if_a.vga_hs !== 1'b0) begin failures++; $display("FAIL pre_reset got rgb=%h req=%b a_hs=%b exp ffff 1 0", if_b.vga_rgb, if_b.pix_data_req, if_a.vga_hs); end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (if_b.vga_rgb !== 16'h0000 || if_b.pix_data_req !== 1'b0 || if_b.pix_x !== 10'h3FF) begin failures++; $display("FAIL async_clear_b got rgb=%h req=%b x=%h exp 0000 0 3ff", if_b.vga_rgb, if_b.pix_data_req, if_b.pix_x); end
      checks++; if (if_a.vga_hs !== 1'b1 || if_a.vga_vs !== 1'b1) begin failures++; $display("FAIL async_clear_a got hs=%b vs=%b exp 1 1", if_a.vga_hs, if_a.vga_vs); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n = 0;
      gen_a = 16'h0;
      gen_b = 16'h0;
      while (n < BFT + 2) begin
         step();
         if (n == 1) begin
            checks++; if (if_a.vga_hs !== 1'b0 || if_a.frame_start !== 1'b1) begin failures++; $display("FAIL restart_a got hs=%b fs=%b exp 0 1", if_a.vga_hs, if_a.frame_start); end
         end
         if (if_b.frame_start) fs_pos.push_back(n);
      end
      ffff_mode = 1'b0;
      fs1 = (fs_pos.size() >= 1) ? fs_pos[0] : -1;
      fs2 = (fs_pos.size() >= 2) ? fs_pos[1] : -1;
      checks++; if (fs_pos.size() !== 2 || fs1 !== 1) begin failures++; $display("FAIL restart_fs got count=%0d first=%0d exp 2 1", fs_pos.size(), fs1); end
      checks++; if (fs2 - fs1 !== BFT) begin failures++; $display("FAIL restart_frame_len got=%0d exp=%0d", fs2 - fs1, BFT); end
   endtask

   initial begin
      rst = 1'b1;
      if_a.pix_data = 16'h0;
      if_b.pix_data = 16'h0;
      test_reset();
      test_sync_timing();
      test_request_window();
      test_frame_alignment();
      test_blanking();
      test_midframe_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
